// File: rtl/song_reader.sv
// Song sequencer: walks a song's ROM entries, issues one note at a time
// and waits for the player to finish each note before fetching the next.
module song_reader #(
    parameter int NOTE_AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic [1:0]         song,
    input  logic               note_done,
    output logic [NOTE_AW+1:0] rom_addr,
    input  logic [11:0]        rom_data,
    output logic [5:0]         note,
    output logic [5:0]         duration,
    output logic               new_note,
    output logic               song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RETRIEVE,
        LOAD,
        WAIT_NOTE,
        DONE
    } state_e;

    state_e               state_q;
    logic [NOTE_AW-1:0]   idx_q;
    logic [NOTE_AW-1:0]   idx_d;
    logic [NOTE_AW+1:0]   rom_addr_q;
    logic [11:0]          hold_q;
    logic [5:0]           note_q;
    logic [5:0]           dur_q;
    logic                 new_note_q;
    logic                 song_done_q;

    assign idx_d = idx_q + 1'b1;

    // rom_addr is loaded on the edge entering FETCH so the ROM word
    // is ready during RETRIEVE; the song input is sampled only there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            hold_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (play) begin
                        rom_addr_q <= {song, idx_q};
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= RETRIEVE;
                end
                RETRIEVE: begin
                    hold_q  <= rom_data;
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (hold_q[5:0] == 6'd0) begin
                        song_done_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (play) begin
                        note_q     <= hold_q[11:6];
                        dur_q      <= hold_q[5:0];
                        new_note_q <= 1'b1;
                        state_q    <= WAIT_NOTE;
                    end
                end
                WAIT_NOTE: begin
                    if (note_done) begin
                        if (&idx_q) begin
                            song_done_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            idx_q      <= idx_d;
                            rom_addr_q <= {song, idx_d};
                            state_q    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;

endmodule
